// File: rtl/sub_bytes_pkg.sv
// sub_bytes_pkg: FSM states and FIPS-197 forward/inverse S-box tables for the SubBytes engine.
package sub_bytes_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [0:255][7:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
    function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
        return inv ? INV_SBOX[b] : FWD_SBOX[b];
    endfunction
endpackage

// File: rtl/sub_bytes_engine_if.sv
// sub_bytes_engine_if: valid/ready input and output channels of the SubBytes engine.
interface sub_bytes_engine_if #(parameter int WIDTH = 128);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_inv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_inv;
    modport master (output in_valid, in_data, in_inv, out_ready,
                    input  in_ready, out_valid, out_data, out_inv);
    modport slave  (input  in_valid, in_data, in_inv, out_ready,
                    output in_ready, out_valid, out_data, out_inv);
endinterface

// File: rtl/sub_bytes_engine_sbox_lane.sv
// sbox_lane: one combinational forward/inverse S-box byte lane.
module sbox_lane import sub_bytes_pkg::*; (
    input  logic [7:0] in_byte,
    input  logic       inv,
    output logic [7:0] out_byte
);
    assign out_byte = sbox(in_byte, inv);
endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: iterative AES SubBytes/InvSubBytes, LANES bytes per cycle.
// Optional SUB_BYTES_ABORT_EN adds an abort input that drops the block in flight.
module sub_bytes_engine import sub_bytes_pkg::*; #(
    parameter int WIDTH = 128,
    parameter int LANES = 4
) (
    input logic clk,
    input logic rst_n,
`ifdef SUB_BYTES_ABORT_EN
    input logic abort,
`endif
    sub_bytes_engine_if.slave bus
);
    localparam int NBYTES = WIDTH / 8;
    localparam int NSTEPS = NBYTES / LANES;
    localparam int SW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    if (WIDTH % 8 != 0 || NBYTES % LANES != 0) begin : g_bad_params
        $error("sub_bytes_engine: WIDTH must be a multiple of 8 and LANES must divide WIDTH/8");
    end

    state_t                  state;
    logic [SW-1:0]           step;
    logic [WIDTH-1:0]        data_q;
    logic                    inv_q;
    logic [LANES-1:0][7:0]   lane_in;
    logic [LANES-1:0][7:0]   lane_out;
    logic                    kill;

`ifdef SUB_BYTES_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    assign bus.in_ready = (state == IDLE);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_in[k] = data_q[(int'(step) * LANES + k) * 8 +: 8];
        sbox_lane u_lane (.in_byte(lane_in[k]), .inv(inv_q), .out_byte(lane_out[k]));
    end

    // out_valid rises one cycle after HOLD is entered, when out_data is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            step          <= '0;
            data_q        <= '0;
            inv_q         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_inv   <= 1'b0;
        end else if (kill && state != IDLE) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    data_q <= bus.in_data;
                    inv_q  <= bus.in_inv;
                    step   <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    for (int k = 0; k < LANES; k++)
                        data_q[(int'(step) * LANES + k) * 8 +: 8] <= lane_out[k];
                    step <= step + 1'b1;
                    if (step == SW'(NSTEPS - 1)) state <= HOLD;
                end
                HOLD: if (!bus.out_valid) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= data_q;
                    bus.out_inv   <= inv_q;
                end else if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: directed bench for LANES=4/1/16 engines against a GF(2^8)-derived S-box model.
module tb_sub_bytes_engine;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic [127:0] in_data = '0;
    logic         in_inv = 0;
    logic         out_ready = 1;
    logic         abort = 0;
    int           sel = 0;
    int           vectors = 0;
    int           errors = 0;
    int           lat[3] = '{5, 17, 2};
    int           pend[3] = '{0, 0, 0};
    logic         ov[3], ir[3], oi[3];
    logic [127:0] od[3];
    logic [7:0]   fwd_t[256], inv_t[256];

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [127:0] sub_ref(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        return r;
    endfunction

    for (genvar c = 0; c < 3; c++) begin : g_cfg
        localparam int LN = (c == 0) ? 4 : (c == 1) ? 1 : 16;
        sub_bytes_engine_if #(.WIDTH(128)) bus ();
        logic         ab;
        logic         pv, pr;
        logic [127:0] pd;
        logic [128:0] q[$];
        assign bus.in_valid  = in_valid && sel == c;
        assign bus.in_data   = in_data;
        assign bus.in_inv    = in_inv;
        assign bus.out_ready = out_ready;
        assign ab = abort && sel == c;
        assign ov[c] = bus.out_valid;
        assign ir[c] = bus.in_ready;
        assign od[c] = bus.out_data;
        assign oi[c] = bus.out_inv;
        sub_bytes_engine #(.WIDTH(128), .LANES(LN)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
`ifdef SUB_BYTES_ABORT_EN
            .abort(ab),
`endif
            .bus(bus)
        );
        // scoreboard: expected results queued at acceptance, checked at delivery
        always @(negedge clk) begin
            logic [128:0] e;
            if (!rst_n) q.delete();
            else begin
                if (ab && !bus.in_ready) q.delete();
                else if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) chk("unexpected_out", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("out_data", bus.out_data, e[127:0]);
                        chk("out_inv", 128'(bus.out_inv), 128'(e[128]));
                    end
                end
                if (pv && !pr && bus.out_valid) chk("hold_stable", bus.out_data, pd);
                if (bus.in_valid && bus.in_ready) q.push_back({bus.in_inv, sub_ref(bus.in_data, bus.in_inv)});
            end
            pv = bus.out_valid;
            pr = bus.out_ready;
            pd = bus.out_data;
            pend[c] = q.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic i);
        int n = 0;
        while (!ir[sel] && n < 100) begin tick(); n++; end
        if (n >= 100) chk("in_ready_timeout", 0, 1);
        in_valid = 1; in_data = d; in_inv = i;
        tick();
        in_valid = 0; in_data = ~d; in_inv = ~i;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!ov[sel] && n < 100) begin tick(); n++; end
        chk("latency", 128'(n), 128'(lat[sel]));
    endtask

    task automatic run(input logic [127:0] d, input logic i);
        send(d, i);
        wait_out();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0]   y;
        logic [127:0] d, keep;
        for (int x = 0; x < 256; x++) begin
            y = 0;
            for (int k = 1; k < 256; k++) if (gmul(8'(x), 8'(k)) == 8'h01) y = 8'(k);
            fwd_t[x] = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
        chk("model_fwd_00", 128'(fwd_t[8'h00]), 128'h63);
        chk("model_fwd_53", 128'(fwd_t[8'h53]), 128'hed);
        chk("model_inv_00", 128'(inv_t[8'h00]), 128'h52);
        chk("model_fips", sub_ref(FIPS_IN, 0), FIPS_OUT);

        #2;
        for (int c = 0; c < 3; c++) begin
            chk("rst_out_valid", 128'(ov[c]), 0);
            chk("rst_in_ready", 128'(ir[c]), 1);
            chk("rst_out_data", od[c], 0);
            chk("rst_out_inv", 128'(oi[c]), 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();

        send(FIPS_IN, 0);
        wait_out();
        chk("fips_fwd", od[0], FIPS_OUT);
        tick();
        send(FIPS_OUT, 1);
        wait_out();
        chk("fips_inv", od[0], FIPS_IN);
        chk("fips_inv_flag", 128'(oi[0]), 1);
        tick();
        send('0, 1);
        wait_out();
        chk("zero_inv", od[0], {16{8'h52}});
        tick();
        send('0, 0);
        wait_out();
        chk("zero_fwd", od[0], {16{8'h63}});
        tick();

        out_ready = 0;
        send(128'h00112233445566778899aabbccddeeff, 0);
        wait_out();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_out_valid", 128'(ov[0]), 1);
            chk("bp_in_ready", 128'(ir[0]), 0);
        end
        out_ready = 1;
        tick();

        for (int c = 0; c < 3; c++) begin
            sel = c;
            for (int j = 0; j < 16; j++) begin
                for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(j * 16 + i);
                run(d, j[0]);
                run(d, ~j[0]);
            end
        end
        sel = 0;

        send(128'hdeadbeefcafef00d0123456789abcdef, 1);
        tick();
        rst_n = 0;
        #1;
        chk("midrun_rst_out_valid", 128'(ov[0]), 0);
        chk("midrun_rst_in_ready", 128'(ir[0]), 1);
        @(posedge clk);
        #1 rst_n = 1;
        tick();
        run(128'h0f0e0d0c0b0a09080706050403020100, 0);

`ifdef SUB_BYTES_ABORT_EN
        out_ready = 0;
        send(128'h3243f6a8885a308d313198a2e0370734, 0);
        wait_out();
        keep = od[0];
        out_ready = 1;
        abort = 1;
        tick();
        abort = 0;
        chk("abort_out_valid", 128'(ov[0]), 0);
        chk("abort_in_ready", 128'(ir[0]), 1);
        chk("abort_out_data_kept", od[0], keep);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_idle_in_ready", 128'(ir[0]), 1);
        chk("abort_idle_out_valid", 128'(ov[0]), 0);
        run(FIPS_IN, 0);
`endif

        tick();
        for (int c = 0; c < 3; c++) chk("pending_empty", 128'(pend[c]), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
